mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the CPU/debug memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_WIDTH   = 16;
   localparam int unsigned DATA_WIDTH   = 8;
   localparam int unsigned STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_CPU,
      REQ_DBG
   } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fixed CPU priority with a debug-port starvation guard,
// registered issue stage and one-cycle read return steered by an owner tag.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = mem_arb_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = mem_arb_pkg::DATA_WIDTH,
   parameter int unsigned STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  mem_enable,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);
   import mem_arb_pkg::*;

   localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0]         starve_cnt;
   logic [CW-1:0]         starve_next;
   logic                  cpu_pick;
   logic                  dbg_pick;
   req_id_t               owner;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q;

   // The counter never passes LIMIT: reaching it hands the next slot to dbg.
   always_comb begin
      dbg_pick    = dbg_req && (!cpu_req || (starve_cnt == LIMIT));
      cpu_pick    = cpu_req && !dbg_pick;
      starve_next = starve_cnt;
      if (!dbg_req || dbg_pick) begin
         starve_next = '0;
      end else if (cpu_pick) begin
         starve_next = starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt  <= '0;
         cpu_gnt     <= 1'b0;
         dbg_gnt     <= 1'b0;
         mem_enable  <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wr_data <= '0;
         owner       <= REQ_NONE;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         starve_cnt <= starve_next;
         cpu_gnt    <= cpu_pick;
         dbg_gnt    <= dbg_pick;
         mem_enable <= cpu_pick || dbg_pick;
         mem_we     <= (cpu_pick && cpu_we) || (dbg_pick && dbg_we);
         if (cpu_pick) begin
            mem_address <= cpu_addr;
            mem_wr_data <= cpu_wdata;
         end else if (dbg_pick) begin
            mem_address <= dbg_addr;
            mem_wr_data <= dbg_wdata;
         end
         // Tag the cycle in which the memory returns data for the read issued now.
         if (mem_enable && !mem_we) begin
            owner <= cpu_gnt ? REQ_CPU : REQ_DBG;
         end else begin
            owner <= REQ_NONE;
         end
         if (cpu_rvalid) begin
            cpu_rdata_q <= mem_rd_data;
         end
         if (dbg_rvalid) begin
            dbg_rdata_q <= mem_rd_data;
         end
      end
   end

   // Read data passes straight through in the response cycle, then is held.
   assign cpu_rvalid = (owner == REQ_CPU);
   assign dbg_rvalid = (owner == REQ_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rd_data : cpu_rdata_q;
   assign dbg_rdata  = dbg_rvalid ? mem_rd_data : dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and read returns,
// a negedge monitor pops and compares them against the DUT and a 64K x 8 memory model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned SL = 4;

   typedef struct {
      req_id_t       id;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gnt_t;

   typedef struct {
      req_id_t       id;
      logic [DW-1:0] data;
   } rd_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_enable, mem_we;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_wr_data, mem_rd_data;
   logic          mem_load;
   logic [DW-1:0] mem [65536];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   gnt_t gq[$];
   rd_t  rq[$];
   int   gcyc[$];

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(SL)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_enable (mem_enable),
      .mem_we     (mem_we),
      .mem_address(mem_address),
      .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
      case (a)
         16'h1234: return 8'h5A;
         16'h0040: return 8'h3C;
         16'h0010: return 8'h11;
         16'h0020: return 8'h22;
         default:  return 8'h00;
      endcase
   endfunction

   // Synchronous 64K x 8 memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 65536; i++) mem[i] <= preset(16'(i));
      end else if (mem_enable) begin
         if (mem_we) mem[mem_address] <= mem_wr_data;
         else        mem_rd_data      <= mem[mem_address];
      end
   end

   // Monitor
   gnt_t          ge;
   rd_t           re;
   req_id_t       gid, rid;
   logic [DW-1:0] rdat, odat, oexp, hold_cpu, hold_dbg;
   int            gc;

   initial begin
      hold_cpu = '0;
      hold_dbg = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetn) begin
            gcyc.delete();
            hold_cpu = '0;
            hold_dbg = '0;
         end else begin
            total++;
            if ((mem_enable !== (cpu_gnt | dbg_gnt)) || (!mem_enable && mem_we)) begin
               bad++;
               $display("FAIL strobe cyc=%0d: mem_enable=%0b mem_we=%0b cpu_gnt=%0b dbg_gnt=%0b",
                        cyc, mem_enable, mem_we, cpu_gnt, dbg_gnt);
            end
            if (cpu_gnt || dbg_gnt) begin
               total++;
               if (cpu_gnt && dbg_gnt) begin
                  bad++;
                  $display("FAIL dual_gnt cyc=%0d: cpu_gnt=1 dbg_gnt=1, want at most one", cyc);
               end else if (gq.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_gnt cyc=%0d: cpu_gnt=%0b dbg_gnt=%0b addr=%h, want no grant",
                           cyc, cpu_gnt, dbg_gnt, mem_address);
               end else begin
                  ge  = gq.pop_front();
                  gid = cpu_gnt ? REQ_CPU : REQ_DBG;
                  if (gid != ge.id || mem_we !== ge.we || mem_address !== ge.addr ||
                      (ge.we && mem_wr_data !== ge.wdata)) begin
                     bad++;
                     $display("FAIL gnt cyc=%0d: got %s we=%0b addr=%h wdata=%h, want %s we=%0b addr=%h wdata=%h",
                              cyc, gid.name(), mem_we, mem_address, mem_wr_data,
                              ge.id.name(), ge.we, ge.addr, ge.wdata);
                  end
                  if (!mem_we) gcyc.push_back(cyc);
               end
            end
            if (cpu_rvalid || dbg_rvalid) begin
               total++;
               if (cpu_rvalid && dbg_rvalid) begin
                  bad++;
                  $display("FAIL dual_rvalid cyc=%0d: both rvalid=1, want at most one", cyc);
               end else if (rq.size() == 0 || gcyc.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_rvalid cyc=%0d: cpu_rvalid=%0b dbg_rvalid=%0b, want none",
                           cyc, cpu_rvalid, dbg_rvalid);
               end else begin
                  re   = rq.pop_front();
                  gc   = gcyc.pop_front();
                  rid  = cpu_rvalid ? REQ_CPU : REQ_DBG;
                  rdat = cpu_rvalid ? cpu_rdata : dbg_rdata;
                  odat = cpu_rvalid ? dbg_rdata : cpu_rdata;
                  oexp = cpu_rvalid ? hold_dbg : hold_cpu;
                  if (rid != re.id || rdat !== re.data || cyc != gc + 1 || odat !== oexp) begin
                     bad++;
                     $display("FAIL rvalid cyc=%0d: got %s data=%h lat=%0d other=%h, want %s data=%h lat=1 other=%h",
                              cyc, rid.name(), rdat, cyc - gc, odat, re.id.name(), re.data, oexp);
                  end
                  if (re.id == REQ_CPU) hold_cpu = re.data;
                  else                  hold_dbg = re.data;
               end
            end
         end
      end
   end

   // Stimulus helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
   endtask

   task automatic idle();
      set_cpu(1'b0, 1'b0, '0, '0);
      set_dbg(1'b0, 1'b0, '0, '0);
   endtask

   task automatic exp_g(input req_id_t id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      gnt_t g;
      g.id = id; g.we = we; g.addr = a; g.wdata = d;
      gq.push_back(g);
   endtask

   task automatic exp_r(input req_id_t id, input logic [DW-1:0] d);
      rd_t r;
      r.id = id; r.data = d;
      rq.push_back(r);
   endtask

   task automatic check_reset(input string tag);
      total++;
      if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_enable, mem_we} != 6'b0 ||
          mem_address != '0 || mem_wr_data != '0 || cpu_rdata != '0 || dbg_rdata != '0) begin
         bad++;
         $display("FAIL %s: gnt=%b%b rvalid=%b%b en=%b we=%b addr=%h wdata=%h rdata=%h/%h, want all zero",
                  tag, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_enable, mem_we,
                  mem_address, mem_wr_data, cpu_rdata, dbg_rdata);
      end
   endtask

   task automatic idle_steps(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      resetn   = 1'b0;
      mem_load = 1'b1;
      idle();
      @(posedge clk);
      #1 mem_load = 1'b0;
      @(negedge clk);
      check_reset("reset_idle");
      set_cpu(1'b1, 1'b0, 16'h1234, 8'h00);
      set_dbg(1'b1, 1'b1, 16'h0200, 8'h55);
      @(posedge clk);
      @(negedge clk);
      check_reset("reset_with_req");
      @(posedge clk);
      #1;
      idle();
      resetn = 1'b1;
      step();

      // CPU read of 0xFFFC (holds 0x00)
      exp_g(REQ_CPU, 1'b0, 16'hFFFC, 8'h00);
      exp_r(REQ_CPU, 8'h00);
      set_cpu(1'b1, 1'b0, 16'hFFFC, 8'h00);
      step();
      idle_steps(3);

      // dbg write then read back 0x0200
      exp_g(REQ_DBG, 1'b1, 16'h0200, 8'hA9);
      exp_g(REQ_DBG, 1'b0, 16'h0200, 8'h00);
      exp_r(REQ_DBG, 8'hA9);
      set_dbg(1'b1, 1'b1, 16'h0200, 8'hA9);
      step();
      set_dbg(1'b1, 1'b0, 16'h0200, 8'h00);
      step();
      idle_steps(3);

      // CPU read giving a nonzero held value
      exp_g(REQ_CPU, 1'b0, 16'h1234, 8'h00);
      exp_r(REQ_CPU, 8'h5A);
      set_cpu(1'b1, 1'b0, 16'h1234, 8'h00);
      step();
      idle_steps(3);

      // Both held: C,C,C,C,D repeating
      for (int i = 0; i < 10; i++) begin
         if (i % 5 == 4) begin
            exp_g(REQ_DBG, 1'b0, 16'h0020, 8'h00);
            exp_r(REQ_DBG, 8'h22);
         end else begin
            exp_g(REQ_CPU, 1'b0, 16'h0010, 8'h00);
            exp_r(REQ_CPU, 8'h11);
         end
      end
      set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
      set_dbg(1'b1, 1'b0, 16'h0020, 8'h00);
      for (int i = 0; i < 10; i++) step();
      idle_steps(3);

      // Alternating single-cycle reads, responses overlap next issue
      exp_g(REQ_CPU, 1'b0, 16'h1234, 8'h00); exp_r(REQ_CPU, 8'h5A);
      exp_g(REQ_DBG, 1'b0, 16'h0040, 8'h00); exp_r(REQ_DBG, 8'h3C);
      exp_g(REQ_CPU, 1'b0, 16'h0010, 8'h00); exp_r(REQ_CPU, 8'h11);
      exp_g(REQ_DBG, 1'b0, 16'h0200, 8'h00); exp_r(REQ_DBG, 8'hA9);
      exp_g(REQ_CPU, 1'b0, 16'hFFFC, 8'h00); exp_r(REQ_CPU, 8'h00);
      exp_g(REQ_DBG, 1'b0, 16'h0020, 8'h00); exp_r(REQ_DBG, 8'h22);
      idle(); set_cpu(1'b1, 1'b0, 16'h1234, 8'h00); step();
      idle(); set_dbg(1'b1, 1'b0, 16'h0040, 8'h00); step();
      idle(); set_cpu(1'b1, 1'b0, 16'h0010, 8'h00); step();
      idle(); set_dbg(1'b1, 1'b0, 16'h0200, 8'h00); step();
      idle(); set_cpu(1'b1, 1'b0, 16'hFFFC, 8'h00); step();
      idle(); set_dbg(1'b1, 1'b0, 16'h0020, 8'h00); step();
      idle_steps(3);

      // CPU writes build starvation; a one-cycle CPU request under dbg priority is dropped
      for (int i = 0; i < 4; i++) exp_g(REQ_CPU, 1'b1, 16'h0300, 8'(i + 1));
      exp_g(REQ_DBG, 1'b0, 16'h0300, 8'h00);
      exp_r(REQ_DBG, 8'h04);
      set_dbg(1'b1, 1'b0, 16'h0300, 8'h00);
      for (int i = 0; i < 4; i++) begin
         set_cpu(1'b1, 1'b1, 16'h0300, 8'(i + 1));
         step();
      end
      set_cpu(1'b1, 1'b1, 16'h0300, 8'hEE);
      step();
      idle_steps(3);
      exp_g(REQ_DBG, 1'b0, 16'h0300, 8'h00);
      exp_r(REQ_DBG, 8'h04);
      set_dbg(1'b1, 1'b0, 16'h0300, 8'h00);
      step();
      idle_steps(3);

      // Reset in the cycle after a CPU read issue, with starve_cnt nonzero
      exp_g(REQ_CPU, 1'b0, 16'h1234, 8'h00);
      set_cpu(1'b1, 1'b0, 16'h1234, 8'h00);
      set_dbg(1'b1, 1'b0, 16'h0040, 8'h00);
      step();
      step();
      resetn = 1'b0;
      idle();
      @(negedge clk);
      check_reset("reset_mid_read");
      step();
      step();
      resetn = 1'b1;
      idle_steps(2);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            exp_g(REQ_DBG, 1'b0, 16'h0020, 8'h00);
            exp_r(REQ_DBG, 8'h22);
         end else begin
            exp_g(REQ_CPU, 1'b0, 16'h0010, 8'h00);
            exp_r(REQ_CPU, 8'h11);
         end
      end
      set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
      set_dbg(1'b1, 1'b0, 16'h0020, 8'h00);
      for (int i = 0; i < 5; i++) step();
      idle_steps(4);

      total++;
      if (gq.size() != 0) begin
         bad++;
         $display("FAIL pending_gnt: %0d grants never seen, want 0", gq.size());
      end
      total++;
      if (rq.size() != 0) begin
         bad++;
         $display("FAIL pending_rvalid: %0d read returns never seen, want 0", rq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
